// File: rtl/mips_core_pkg.sv
// Shared branch-tag constants and the tag payload type used by the
// allocator and its consumers.
package mips_core_pkg;

    localparam int unsigned BRANCH_TAG_COUNT = 8;
    localparam int unsigned BRANCH_TAG_W     = $clog2(BRANCH_TAG_COUNT);

    typedef struct packed {
        logic [BRANCH_TAG_W-1:0] id;
        logic                    color;
    } branch_tag_t;

endpackage

// File: rtl/branch_tag_allocator_if.sv
// Decode/execute-facing bus of the branch tag allocator: tag requests,
// resolves, misses and the resulting kill/occupancy outputs.
interface branch_tag_allocator_if
    import mips_core_pkg::*;
#(
    parameter int unsigned NUM_TAGS = BRANCH_TAG_COUNT,
    parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
);

    logic                alloc_req;
    logic                alloc_grant;
    logic [TAG_W-1:0]    alloc_id;
    logic                alloc_color;
    logic                full;

    logic                resolve_valid;
    logic [TAG_W-1:0]    resolve_id;
    logic                resolve_color;

    logic                miss_valid;
    logic [TAG_W-1:0]    miss_id;
    logic                miss_color;

    logic                kill_valid;
    logic [NUM_TAGS-1:0] kill_mask;
    logic [NUM_TAGS-1:0] live_mask;
    logic [TAG_W:0]      count;

    modport master (
        output alloc_req, resolve_valid, resolve_id, resolve_color,
               miss_valid, miss_id, miss_color,
        input  alloc_grant, alloc_id, alloc_color, full,
               kill_valid, kill_mask, live_mask, count
    );

    modport slave (
        input  alloc_req, resolve_valid, resolve_id, resolve_color,
               miss_valid, miss_id, miss_color,
        output alloc_grant, alloc_id, alloc_color, full,
               kill_valid, kill_mask, live_mask, count
    );

endinterface

// File: rtl/branch_tag_age_cmp.sv
// Relative age of two in-flight branch tags: a_younger is set when tag A
// was allocated after tag B, using the wrap color to order across a wrap.
module branch_tag_age_cmp
    import mips_core_pkg::*;
#(
    parameter int unsigned TAG_W = BRANCH_TAG_W
) (
    input  logic [TAG_W-1:0] a_id,
    input  logic             a_color,
    input  logic [TAG_W-1:0] b_id,
    input  logic             b_color,
    output logic             a_younger
);

    always_comb begin
        a_younger = 1'b0;
        if (a_color == b_color) begin
            a_younger = (a_id > b_id);
        end else begin
            a_younger = (a_id < b_id);
        end
    end

endmodule

// File: rtl/branch_tag_allocator.sv
// In-order branch tag allocator with out-of-order resolve and miss rollback.
// Optional statistics counters are enabled by defining BRANCH_TAG_STATS_EN.
module branch_tag_allocator
    import mips_core_pkg::*;
#(
    parameter int unsigned NUM_TAGS = BRANCH_TAG_COUNT,
    parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_tag_allocator_if.slave bus
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]    head_q;
    logic                head_color_q;
    logic [TAG_W-1:0]    tail_q;
    logic                tail_color_q;
    logic [NUM_TAGS-1:0] live_q;
    logic [NUM_TAGS-1:0] slot_color_q;
    logic                kill_valid_q;
    logic [NUM_TAGS-1:0] kill_mask_q;

    logic [CNT_W-1:0]    occ;
    logic                full;
    logic                grant;
    logic                miss_ok;
    logic                resolve_ok;
    logic                head_adv;
    logic [NUM_TAGS-1:0] younger;
    logic [NUM_TAGS-1:0] kill_vec;
    logic [NUM_TAGS-1:0] clear_vec;
    logic [NUM_TAGS-1:0] set_vec;

    // Occupancy includes resolved slots the head has not yet stepped over.
    assign occ  = {tail_color_q, tail_q} - {head_color_q, head_q};
    assign full = (occ == CNT_W'(NUM_TAGS));

    // full comes from registered state, so a same-cycle resolve never opens a slot.
    assign grant = bus.alloc_req & ~full & ~bus.miss_valid;

    assign miss_ok = bus.miss_valid & live_q[bus.miss_id]
                   & (slot_color_q[bus.miss_id] == bus.miss_color);

    assign resolve_ok = bus.resolve_valid & live_q[bus.resolve_id]
                      & (slot_color_q[bus.resolve_id] == bus.resolve_color);

    assign head_adv = ~live_q[head_q] & (occ != '0);

    for (genvar i = 0; i < NUM_TAGS; i++) begin : g_age
        branch_tag_age_cmp #(
            .TAG_W (TAG_W)
        ) u_age_cmp (
            .a_id      (TAG_W'(i)),
            .a_color   (slot_color_q[i]),
            .b_id      (bus.miss_id),
            .b_color   (bus.miss_color),
            .a_younger (younger[i])
        );
    end

    // A killed tag is cleared regardless, so a racing resolve on it is moot.
    always_comb begin
        kill_vec  = '0;
        clear_vec = '0;
        set_vec   = '0;
        if (miss_ok) begin
            kill_vec  = live_q & younger;
            clear_vec = kill_vec | (NUM_TAGS'(1) << bus.miss_id);
        end
        if (resolve_ok) begin
            clear_vec = clear_vec | (NUM_TAGS'(1) << bus.resolve_id);
        end
        if (grant) begin
            set_vec = NUM_TAGS'(1) << tail_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            head_color_q <= 1'b0;
            tail_q       <= '0;
            tail_color_q <= 1'b0;
            live_q       <= '0;
            slot_color_q <= '0;
            kill_valid_q <= 1'b0;
            kill_mask_q  <= '0;
        end else begin
            live_q <= (live_q & ~clear_vec) | set_vec;
            if (grant) begin
                slot_color_q[tail_q] <= tail_color_q;
            end
            // Rollback resumes allocation right after the mispredicted tag.
            if (miss_ok) begin
                {tail_color_q, tail_q} <= {bus.miss_color, bus.miss_id} + CNT_W'(1);
            end else if (grant) begin
                {tail_color_q, tail_q} <= {tail_color_q, tail_q} + CNT_W'(1);
            end
            if (head_adv) begin
                {head_color_q, head_q} <= {head_color_q, head_q} + CNT_W'(1);
            end
            kill_valid_q <= miss_ok;
            kill_mask_q  <= kill_vec;
        end
    end

    assign bus.alloc_grant = grant;
    assign bus.alloc_id    = tail_q;
    assign bus.alloc_color = tail_color_q;
    assign bus.full        = full;
    assign bus.count       = occ;
    assign bus.live_mask   = live_q;
    assign bus.kill_valid  = kill_valid_q;
    assign bus.kill_mask   = kill_mask_q;

`ifdef BRANCH_TAG_STATS_EN
    logic [31:0] stat_alloc;
    logic [31:0] stat_miss;
    logic [31:0] stat_killed;
    logic [31:0] stat_full_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_alloc       <= '0;
            stat_miss        <= '0;
            stat_killed      <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (grant) begin
                stat_alloc <= stat_alloc + 32'd1;
            end
            if (miss_ok) begin
                stat_miss <= stat_miss + 32'd1;
            end
            if (kill_valid_q) begin
                stat_killed <= stat_killed + 32'($countones(kill_mask_q));
            end
            if (bus.alloc_req & full) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
        end
    end

`ifdef SIMULATION
    int unsigned stat_events [string];

    function automatic void stats_event(input string name);
        if (stat_events.exists(name)) begin
            stat_events[name] = stat_events[name] + 1;
        end else begin
            stat_events[name] = 1;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            stat_events.delete();
        end else if (bus.alloc_req & full) begin
            stats_event("tag_full");
        end
    end
`endif
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Directed bench for branch_tag_allocator against a queue-based model of
// in-flight tags, plus literal expectations at key points.
module tb_branch_tag_allocator;
    import mips_core_pkg::*;

    localparam int N  = 8;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_tag_allocator_if #(.NUM_TAGS(N), .TAG_W(TW)) bus ();

    branch_tag_allocator #(.NUM_TAGS(N), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered list of allocated-but-not-retired tags, oldest first.
    typedef struct {
        branch_tag_t tag;
        bit          done;
    } ent_t;

    ent_t        q[$];
    branch_tag_t m_tail;
    bit          m_kv;
    logic [N-1:0] m_km;

    function automatic branch_tag_t next_tag(input branch_tag_t t);
        branch_tag_t r;
        int s;
        s = (int'(t.color) * N + int'(t.id) + 1) % (2 * N);
        r.id    = TW'(s % N);
        r.color = (s >= N);
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit g;
        bit pop;
        int mk;
        logic [N-1:0] km;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail = '0;
            m_kv   = 1'b0;
            m_km   = '0;
        end else begin
            g   = bus.alloc_req && (q.size() < N) && !bus.miss_valid;
            pop = (q.size() > 0) && q[0].done;
            mk  = -1;
            km  = '0;
            if (bus.miss_valid) begin
                foreach (q[k]) begin
                    if (!q[k].done && q[k].tag.id == bus.miss_id && q[k].tag.color == bus.miss_color)
                        mk = k;
                end
            end
            if (mk >= 0) begin
                for (int j = mk + 1; j < q.size(); j++)
                    if (!q[j].done) km[q[j].tag.id] = 1'b1;
                q[mk].done = 1'b1;
                m_tail = next_tag(q[mk].tag);
                while (q.size() > mk + 1) void'(q.pop_back());
            end
            if (bus.resolve_valid) begin
                foreach (q[k]) begin
                    if (!q[k].done && q[k].tag.id == bus.resolve_id && q[k].tag.color == bus.resolve_color)
                        q[k].done = 1'b1;
                end
            end
            if (g) begin
                e.tag  = m_tail;
                e.done = 1'b0;
                q.push_back(e);
                m_tail = next_tag(m_tail);
            end
            if (pop) void'(q.pop_front());
            m_kv = (mk >= 0);
            m_km = km;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] lm;
            lm = '0;
            foreach (q[k]) if (!q[k].done) lm[q[k].tag.id] = 1'b1;
            chk("alloc_grant", 32'(bus.alloc_grant),
                32'(bus.alloc_req && (q.size() < N) && !bus.miss_valid));
            chk("alloc_id",    32'(bus.alloc_id),    32'(m_tail.id));
            chk("alloc_color", 32'(bus.alloc_color), 32'(m_tail.color));
            chk("full",        32'(bus.full),        32'(q.size() == N));
            chk("count",       32'(bus.count),       32'(q.size()));
            chk("live_mask",   32'(bus.live_mask),   32'(lm));
            chk("kill_valid",  32'(bus.kill_valid),  32'(m_kv));
            chk("kill_mask",   32'(bus.kill_mask),   32'(m_km));
        end
    end

    task automatic set_in(input bit r, input bit req, input bit rv, input int rid, input bit rc,
                          input bit mv, input int mid, input bit mc);
        rst               = r;
        bus.alloc_req     = req;
        bus.resolve_valid = rv;
        bus.resolve_id    = TW'(rid);
        bus.resolve_color = rc;
        bus.miss_valid    = mv;
        bus.miss_id       = TW'(mid);
        bus.miss_color    = mc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit req, input bit rv, input int rid, input bit rc,
                         input bit mv, input int mid, input bit mc);
        set_in(r, req, rv, rid, rc, mv, mid, mc);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int n);
        repeat (n) drive(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},       32'(bus.count),       32'd0);
        chk({tag, "_full"},        32'(bus.full),        32'd0);
        chk({tag, "_kill_valid"},  32'(bus.kill_valid),  32'd0);
        chk({tag, "_kill_mask"},   32'(bus.kill_mask),   32'd0);
        chk({tag, "_live_mask"},   32'(bus.live_mask),   32'd0);
        chk({tag, "_alloc_id"},    32'(bus.alloc_id),    32'd0);
        chk({tag, "_alloc_color"}, 32'(bus.alloc_color), 32'd0);
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk_en = 1'b1;
        do_reset();
        chk_reset_outputs("reset");

        // Fill to full: ten requests, eight grants.
        alloc(10);
        chk("fill_full",        32'(bus.full),        32'd1);
        chk("fill_count",       32'(bus.count),       32'd8);
        chk("fill_live",        32'(bus.live_mask),   32'hFF);
        chk("fill_alloc_id",    32'(bus.alloc_id),    32'd0);
        chk("fill_alloc_color", 32'(bus.alloc_color), 32'd1);

        // Out-of-order resolve: head waits for id 0.
        drive(0, 0, 1, 3, 0, 0, 0, 0);
        chk("ooo_r3_count", 32'(bus.count), 32'd8);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        chk("ooo_r0_count", 32'(bus.count), 32'd8);
        chk("ooo_r0_live",  32'(bus.live_mask), 32'hF6);
        idle(1);
        chk("ooo_head1_count", 32'(bus.count), 32'd7);
        chk("ooo_head1_live",  32'(bus.live_mask), 32'hF6);
        idle(1);
        chk("ooo_head_hold", 32'(bus.count), 32'd7);

        // Miss across the wrap.
        do_reset();
        alloc(8);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, i, 0, 0, 0, 0);
        idle(3);
        chk("wrap_pre_count", 32'(bus.count), 32'd2);
        alloc(3);
        chk("wrap_alloc_live", 32'(bus.live_mask), 32'hC7);
        drive(0, 0, 0, 0, 0, 1, 7, 0);
        chk("wrap_kill_valid",  32'(bus.kill_valid),  32'd1);
        chk("wrap_kill_mask",   32'(bus.kill_mask),   32'h07);
        chk("wrap_tail_id",     32'(bus.alloc_id),    32'd0);
        chk("wrap_tail_color",  32'(bus.alloc_color), 32'd1);
        chk("wrap_live",        32'(bus.live_mask),   32'h40);
        chk("wrap_count",       32'(bus.count),       32'd2);
        idle(1);
        chk("wrap_kill_pulse", 32'(bus.kill_valid), 32'd0);

        // Stale inputs change nothing.
        drive(0, 0, 1, 6, 1, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 1, 3, 0);
        chk("stale_live",       32'(bus.live_mask),  32'h40);
        chk("stale_kill_valid", 32'(bus.kill_valid), 32'd0);
        chk("stale_count",      32'(bus.count),      32'd2);

        // Simultaneous alloc, miss on 1 and resolve of younger 4.
        do_reset();
        alloc(6);
        set_in(0, 1, 1, 4, 0, 1, 1, 0);
        #1;
        chk("sim_no_grant", 32'(bus.alloc_grant), 32'd0);
        tick();
        chk("sim_kill_valid", 32'(bus.kill_valid), 32'd1);
        chk("sim_kill_mask",  32'(bus.kill_mask),  32'h3C);
        chk("sim_live",       32'(bus.live_mask),  32'h01);
        chk("sim_count",      32'(bus.count),      32'd2);
        chk("sim_tail",       32'(bus.alloc_id),   32'd2);
        idle(2);

        // Reset mid-operation with a miss in the same cycle.
        do_reset();
        alloc(5);
        chk("rstmid_pre_count", 32'(bus.count), 32'd5);
        drive(1, 1, 0, 0, 0, 1, 1, 0);
        chk_reset_outputs("rstmid");
        idle(1);
        chk("rstmid_kill_after", 32'(bus.kill_valid), 32'd0);
        chk("rstmid_count_after", 32'(bus.count), 32'd0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_tag_allocator.md
# branch_tag_allocator

Allocates in-order branch tags (id plus color bit) to decoded branches. Tracks which tags are still in flight, and frees them when they resolve. On a misprediction reported by the hazard path (`branch_miss`, `branch_id`, `color_bit`), it rolls the allocation pointer back and produces a kill mask of every younger in-flight tag. The block sits between decode/rename, which requests tags, and the execute/hazard path, which consumes the id/color pair this block issues.

## Interface
Parameters:
- `NUM_TAGS`, default 8: number of tags. Must be a power of 2 and ≥ 2.
- `TAG_W`, default `$clog2(NUM_TAGS)`: tag id width.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset. Synchronous, active-high.
- `alloc_req`, in, 1: decode holds a branch that needs a tag this cycle.
- `alloc_grant`, out, 1: tag granted this cycle.
- `alloc_id`, out, `TAG_W`: granted tag id, equal to the current tail.
- `alloc_color`, out, 1: color of the granted tag.
- `full`, out, 1: all tags in flight. Feeds decode stall.
- `resolve_valid`, in, 1: a branch resolved correctly in execute.
- `resolve_id`, in, `TAG_W`: id of the resolving branch.
- `resolve_color`, in, 1: color of the resolving branch.
- `miss_valid`, in, 1: branch misprediction.
- `miss_id`, in, `TAG_W`: id of the mispredicted branch.
- `miss_color`, in, 1: color of the mispredicted branch.
- `kill_valid`, out, 1: a kill mask is presented this cycle.
- `kill_mask`, out, `NUM_TAGS`: one bit per tag id to squash.
- `live_mask`, out, `NUM_TAGS`: tags currently in flight.
- `count`, out, `TAG_W+1`: number of in-flight tags.

## Operation
State:
- `head` / `tail` pointers, each with a wrap color bit.
- `live[NUM_TAGS]` and `slot_color[NUM_TAGS]` arrays.
- Registered kill output.

Allocate:
- Grant rule: `alloc_grant = alloc_req & ~full & ~miss_valid`.
- On grant: set `live[tail]`, write `slot_color[tail]` with the tail color, and increment `tail`.
- The tail color toggles when `tail` wraps from `NUM_TAGS-1` to 0.

Resolve:
- A resolve is valid only if `live[resolve_id]` is set and `slot_color[resolve_id] == resolve_color`. A valid resolve clears `live[resolve_id]`.
- Stale or duplicate resolves are ignored.

Head advance:
- Each cycle, `head` advances by at most one while `live[head]` is 0 and `head != tail`.
- `head` color toggles on wrap.
- `count = tail - head`, modulo arithmetic with color bits; this occupancy also counts resolved-but-not-retired slots.
- `full = (count == NUM_TAGS)`.

Miss:
- A miss is valid only if `live[miss_id]` is set and the colors match. Invalid misses are ignored, with no kill.
- Age rule: tag T is younger than the miss tag M if (`color(T) == color(M)` and `id(T) > id(M)`), or (`color(T) != color(M)` and `id(T) < id(M)`).
- Next-cycle `kill_mask` holds every live tag younger than `miss_id`.
- The same edge clears `live` for those tags and for `miss_id` itself.
- `tail` is set to `miss_id+1`, with the color carried across the wrap.

Simultaneous events:
- Resolve and miss in the same cycle: the resolve applies only if its tag is not killed.
- Alloc and miss in the same cycle: no grant.
- Resolve that frees a tag while `full`: no same-cycle grant, because `full` is computed from registered state.

Reset mid-operation: clears all state and drops any pending kill. No kill is emitted for tags in flight at reset.

## Timing
- `alloc_grant`, `alloc_id` and `alloc_color` are combinational from `alloc_req` and registered state.
- `full`, `count` and `live_mask` are registered-state outputs.
- `kill_valid` and `kill_mask` are registered: they assert exactly one cycle after a valid miss, for one cycle.
- Reset values:
  - `head = tail = 0`, both colors 0, `live = 0`.
  - `full = 0`, `count = 0`, `kill_valid = 0`, `kill_mask = 0`, `live_mask = 0`.
  - `alloc_id = 0`, `alloc_color = 0`.

## Configuration
- `BRANCH_TAG_STATS_EN` defined: internal 32-bit counters `stat_alloc`, `stat_miss`, `stat_killed` (popcount of each `kill_mask`) and `stat_full_cycles` (cycles with `alloc_req & full`).
  - All counters clear on `rst`.
  - Under `SIMULATION` they additionally report via `stats_event("tag_full")` on each full-stall cycle.
- `BRANCH_TAG_STATS_EN` undefined: no counters are synthesized and there are no stats events. Functional behaviour is identical.

## Structure
- `mips_core_pkg` holds:
  - the `BRANCH_TAG_COUNT` constant;
  - the `branch_tag_t` struct `{logic [TAG_W-1:0] id; logic color;}`.
- One combinational sub-module, `branch_tag_age_cmp`: inputs tag A and tag B, output `a_younger`. It is instantiated `NUM_TAGS` times to build the kill mask.

## Test plan
- **Fill to full:** reset, then `alloc_req` held for 10 cycles with `NUM_TAGS` = 8.
  - Grants ids 0..7 with color 0.
  - `full = 1` from cycle 8 on; no further grants.
  - `count = 8`.
- **Out-of-order resolve:** fill, resolve ids 3 then 0.
  - After resolving id 3: `head` stays at 0.
  - After resolving id 0: `head` advances to 1 in the next cycle only.
  - `live_mask = 8'b1111_0110`.
- **Miss with wrap:** fill ids 0..7, resolve 0..5, allocate ids 0..2 with color 1, then miss on id 7 color 0.
  - Next cycle: `kill_valid = 1`, `kill_mask = 8'b0000_0111`.
  - `tail = 0`, tail color 1.
- **Stale inputs:** resolve id 2 with the wrong color; miss on a non-live id.
  - No state change, `kill_valid = 0`.
- **Simultaneous events:** alloc, miss on id 1, and resolve of id 4 (younger) in the same cycle.
  - No grant; the resolve is dropped.
  - `kill_mask` includes bit 4.
- **Reset mid-operation:** 5 tags live plus a pending miss, assert `rst`.
  - All outputs reach their reset values at the next edge.
  - `kill_valid` stays 0.
